// File: rtl/pa_ifu_ipack_ctrl_pkg.sv
// Shared constants for the IFU instruction package buffer controller.
package pa_ifu_ipack_ctrl_pkg;
  localparam int         IPACK_ENTRY_NUM = 8;
  localparam int         IPACK_PTR_W     = 3;
  // Low two bits of a halfword that mark the start of a 32-bit instruction.
  localparam logic [1:0] INST_32_OPCODE  = 2'b11;
endpackage

// File: rtl/pa_ifu_ipack_head_dec.sv
// Combinational decode of the two halfwords at the head of the ring:
// instruction length, completeness, access error and how many entries retire.
module pa_ifu_ipack_head_dec
  import pa_ifu_ipack_ctrl_pkg::*;
(
  input  logic [15:0] h0_inst,
  input  logic        h0_vld,
  input  logic        h0_err,
  input  logic [15:0] h1_inst,
  input  logic        h1_vld,
  input  logic        h1_err,
  output logic        inst_vld,
  output logic [31:0] inst,
  output logic        inst_32,
  output logic        acc_err,
  output logic        retire_two
);

  // A faulted head halfword is always issued alone so the error surfaces early.
  always_comb begin
    inst_32    = ~h0_err & (h0_inst[1:0] == INST_32_OPCODE);
    inst_vld   = h0_vld & (~inst_32 | h1_vld);
    inst       = inst_32 ? {h1_inst, h0_inst} : {16'h0000, h0_inst};
    acc_err    = inst_32 ? h1_err : h0_err;
    retire_two = inst_32;
  end

endmodule

// File: rtl/pa_ifu_ipack_ctrl.sv
// Instruction package buffer controller: owns create/retire pointers and the
// occupancy count, steers fetched halfwords into the ring and issues complete
// instructions to ID.
// Handshake: an instruction transfers in a cycle where ipack_id_inst_vld and
// id_ipack_inst_acpt are both high and no flush is present; the presented
// instruction holds steady while vld is high and acpt is low.
// Optional build macro E906_IPACK_BYPASS_EN: an empty buffer presents the
// fetched instruction in the same cycle; accepted halfwords are never written.
module pa_ifu_ipack_ctrl
  import pa_ifu_ipack_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM = IPACK_ENTRY_NUM,
  parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
  input  logic                    ipack_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    ipack_buf_flush,
  input  logic                    if_ipack_fetch_vld,
  input  logic [1:0]              if_ipack_fetch_num,
  input  logic [31:0]             if_ipack_fetch_data,
  input  logic                    if_ipack_fetch_acc_err,
  output logic                    ipack_if_fetch_rdy,
  output logic [ENTRY_NUM-1:0]    ipack_entry_create_en,
  output logic [ENTRY_NUM-1:0]    ipack_entry_create_icg_en,
  output logic [ENTRY_NUM-1:0]    ipack_entry_retire_en,
  output logic [16*ENTRY_NUM-1:0] ipack_entry_upd_inst,
  output logic [ENTRY_NUM-1:0]    ipack_entry_upd_acc_err,
  input  logic [ENTRY_NUM-1:0]    ipack_entry_vld,
  input  logic [16*ENTRY_NUM-1:0] ipack_entry_inst,
  input  logic [ENTRY_NUM-1:0]    ipack_entry_acc_err,
  output logic                    ipack_id_inst_vld,
  output logic [31:0]             ipack_id_inst,
  output logic                    ipack_id_inst_32,
  output logic                    ipack_id_acc_err,
  input  logic                    id_ipack_inst_acpt,
  output logic                    ipack_buf_empty,
  output logic                    ipack_buf_full
);

  localparam logic [PTR_W:0] RDY_MAX  = (PTR_W+1)'(ENTRY_NUM - 2);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(ENTRY_NUM);

  logic [PTR_W-1:0] create_ptr, create_ptr1, retire_ptr, retire_ptr1;
  logic [PTR_W-1:0] wr_adv, ret_adv;
  logic [PTR_W:0]   count;
  logic             wr, wr_two, wr_lo, wr_hi, bypass_sel, ret;
  logic [15:0]      ent_inst [ENTRY_NUM];
  logic [15:0]      dec_h0_inst, dec_h1_inst;
  logic             dec_h0_vld, dec_h0_err, dec_h1_vld, dec_h1_err;
  logic             dec_vld, dec_two;

  assign ipack_if_fetch_rdy = (count <= RDY_MAX);
  assign ipack_buf_empty    = (count == '0);
  assign ipack_buf_full     = (count == FULL_CNT);
  assign wr                 = if_ipack_fetch_vld & ipack_if_fetch_rdy & ~ipack_buf_flush;
  assign wr_two             = (if_ipack_fetch_num == 2'd2);
  assign create_ptr1        = create_ptr + PTR_W'(1);
  assign retire_ptr1        = retire_ptr + PTR_W'(1);

`ifdef E906_IPACK_BYPASS_EN
  assign bypass_sel = wr & (count == '0);
`else
  assign bypass_sel = 1'b0;
`endif

  // Unpack entry read-back data into an indexable array.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      ent_inst[i] = ipack_entry_inst[i*16 +: 16];
    end
  end

  // Select the halfword pair to decode: ring head, or raw fetch data on bypass.
  always_comb begin
    dec_h0_inst = ent_inst[retire_ptr];
    dec_h0_vld  = ipack_entry_vld[retire_ptr];
    dec_h0_err  = ipack_entry_acc_err[retire_ptr];
    dec_h1_inst = ent_inst[retire_ptr1];
    dec_h1_vld  = ipack_entry_vld[retire_ptr1];
    dec_h1_err  = ipack_entry_acc_err[retire_ptr1];
    if (bypass_sel) begin
      dec_h0_inst = if_ipack_fetch_data[15:0];
      dec_h0_vld  = 1'b1;
      dec_h0_err  = if_ipack_fetch_acc_err;
      dec_h1_inst = if_ipack_fetch_data[31:16];
      dec_h1_vld  = wr_two;
      dec_h1_err  = if_ipack_fetch_acc_err;
    end
  end

  pa_ifu_ipack_head_dec u_head_dec (
    .h0_inst    (dec_h0_inst),
    .h0_vld     (dec_h0_vld),
    .h0_err     (dec_h0_err),
    .h1_inst    (dec_h1_inst),
    .h1_vld     (dec_h1_vld),
    .h1_err     (dec_h1_err),
    .inst_vld   (dec_vld),
    .inst       (ipack_id_inst),
    .inst_32    (ipack_id_inst_32),
    .acc_err    (ipack_id_acc_err),
    .retire_two (dec_two)
  );

  // Gating on count keeps vld low immediately on reset regardless of entry state.
  assign ipack_id_inst_vld = dec_vld & ~ipack_buf_flush & ((count != '0) | bypass_sel);
  assign ret               = ipack_id_inst_vld & id_ipack_inst_acpt;
  assign wr_adv            = wr  ? (wr_two  ? PTR_W'(2) : PTR_W'(1)) : '0;
  assign ret_adv           = ret ? (dec_two ? PTR_W'(2) : PTR_W'(1)) : '0;
  // Bypassed halfwords that ID accepts are not written into the ring.
  assign wr_lo             = wr & ~(bypass_sel & ret);
  assign wr_hi             = wr & wr_two & ~(bypass_sel & ret & dec_two);

  // Per-entry create/retire strobes and write data.
  always_comb begin
    ipack_entry_create_en   = '0;
    ipack_entry_retire_en   = '0;
    ipack_entry_upd_inst    = '0;
    ipack_entry_upd_acc_err = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      ipack_entry_create_en[i]   = (wr_lo & (PTR_W'(i) == create_ptr)) |
                                   (wr_hi & (PTR_W'(i) == create_ptr1));
      ipack_entry_retire_en[i]   = ret & ~bypass_sel &
                                   ((PTR_W'(i) == retire_ptr) | (dec_two & (PTR_W'(i) == retire_ptr1)));
      ipack_entry_upd_inst[i*16 +: 16] = (PTR_W'(i) == create_ptr) ? if_ipack_fetch_data[15:0]
                                                                   : if_ipack_fetch_data[31:16];
      ipack_entry_upd_acc_err[i] = if_ipack_fetch_acc_err;
    end
  end

  assign ipack_entry_create_icg_en = ipack_entry_create_en;

  // Pointer and occupancy update; flush returns everything to the origin.
  always_ff @(posedge ipack_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      create_ptr <= '0;
      retire_ptr <= '0;
      count      <= '0;
    end else if (ipack_buf_flush) begin
      create_ptr <= '0;
      retire_ptr <= '0;
      count      <= '0;
    end else begin
      create_ptr <= create_ptr + wr_adv;
      retire_ptr <= retire_ptr + ret_adv;
      count      <= count + {1'b0, wr_adv} - {1'b0, ret_adv};
    end
  end

endmodule

// File: tb/tb_pa_ifu_ipack_ctrl.sv
// Bench for pa_ifu_ipack_ctrl: models the external entry ring and keeps a
// halfword queue as the reference for buffer contents.
module tb_pa_ifu_ipack_ctrl;

  localparam int N = 8;

  logic          clk, rst_b, flush, fetch_vld, fetch_err, acpt;
  logic [1:0]    fetch_num;
  logic [31:0]   fetch_data;
  logic          fetch_rdy, id_vld, id_32, id_err, buf_empty, buf_full;
  logic [31:0]   id_inst;
  logic [N-1:0]  create_en, icg_en, retire_en, upd_err, ent_vld, ent_err;
  logic [16*N-1:0] upd_inst, ent_inst;

  logic [16:0] exp_q[$];
  int          wr_pos, rd_pos, errors, checks;

  pa_ifu_ipack_ctrl dut (
    .ipack_cpuclk              (clk),
    .cpurst_b                  (rst_b),
    .ipack_buf_flush           (flush),
    .if_ipack_fetch_vld        (fetch_vld),
    .if_ipack_fetch_num        (fetch_num),
    .if_ipack_fetch_data       (fetch_data),
    .if_ipack_fetch_acc_err    (fetch_err),
    .ipack_if_fetch_rdy        (fetch_rdy),
    .ipack_entry_create_en     (create_en),
    .ipack_entry_create_icg_en (icg_en),
    .ipack_entry_retire_en     (retire_en),
    .ipack_entry_upd_inst      (upd_inst),
    .ipack_entry_upd_acc_err   (upd_err),
    .ipack_entry_vld           (ent_vld),
    .ipack_entry_inst          (ent_inst),
    .ipack_entry_acc_err       (ent_err),
    .ipack_id_inst_vld         (id_vld),
    .ipack_id_inst             (id_inst),
    .ipack_id_inst_32          (id_32),
    .ipack_id_acc_err          (id_err),
    .id_ipack_inst_acpt        (acpt),
    .ipack_buf_empty           (buf_empty),
    .ipack_buf_full            (buf_full)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry ring model: the entries live outside the controller.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ent_vld <= '0;
      ent_err <= '0;
      ent_inst <= '0;
    end else if (flush) begin
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (create_en[i]) begin
          ent_vld[i]           <= 1'b1;
          ent_inst[i*16 +: 16] <= upd_inst[i*16 +: 16];
          ent_err[i]           <= upd_err[i];
        end else if (retire_en[i]) begin
          ent_vld[i] <= 1'b0;
        end
      end
    end
  end

  task automatic set_idle();
    fetch_vld = 0; fetch_num = 2'd1; fetch_data = '0; fetch_err = 0; acpt = 0; flush = 0;
  endtask

  task automatic model_clear();
    exp_q.delete(); wr_pos = 0; rd_pos = 0;
  endtask

  // Driver + scoreboard: one clock cycle, outputs compared to the queue model.
  task automatic drive_cycle(input logic fv, input logic [1:0] num, input logic [31:0] data,
                             input logic err, input logic ac, input logic fl);
    logic e_vld, e_32, e_err, wr;
    logic [31:0] e_inst;
    logic [N-1:0] e_cmask, e_rmask;
    int n_ret, sz;
    fetch_vld = fv; fetch_num = num; fetch_data = data; fetch_err = err; acpt = ac; flush = fl;
    #1;
    sz = exp_q.size();
    e_vld = 0; e_32 = 0; e_err = 0; e_inst = '0; n_ret = 0;
    if (sz > 0) begin
      e_32 = !exp_q[0][16] && (exp_q[0][1:0] == 2'b11);
      if (!e_32) begin
        e_vld = 1; e_inst = {16'h0, exp_q[0][15:0]}; e_err = exp_q[0][16]; n_ret = 1;
      end else if (sz >= 2) begin
        e_vld = 1; e_inst = {exp_q[1][15:0], exp_q[0][15:0]}; e_err = exp_q[1][16]; n_ret = 2;
      end
    end
    if (fl) e_vld = 0;
    wr = fv && (sz <= N - 2) && !fl;
    e_cmask = '0;
    if (wr) begin
      e_cmask[wr_pos] = 1'b1;
      if (num == 2'd2) e_cmask[(wr_pos + 1) % N] = 1'b1;
    end
    e_rmask = '0;
    if (e_vld && ac) begin
      e_rmask[rd_pos] = 1'b1;
      if (n_ret == 2) e_rmask[(rd_pos + 1) % N] = 1'b1;
    end
    checks++; if (id_vld !== e_vld) begin errors++; $display("FAIL sb_vld got=%0b exp=%0b t=%0t", id_vld, e_vld, $time); end
    checks++; if (fetch_rdy !== (sz <= N - 2)) begin errors++; $display("FAIL sb_rdy got=%0b cnt=%0d", fetch_rdy, sz); end
    checks++; if (buf_empty !== (sz == 0) || buf_full !== (sz == N)) begin errors++; $display("FAIL sb_status empty=%0b full=%0b cnt=%0d", buf_empty, buf_full, sz); end
    checks++; if (create_en !== e_cmask || icg_en !== e_cmask) begin errors++; $display("FAIL sb_create got=%h icg=%h exp=%h", create_en, icg_en, e_cmask); end
    checks++; if (retire_en !== e_rmask) begin errors++; $display("FAIL sb_retire got=%h exp=%h", retire_en, e_rmask); end
    if (e_vld) begin
      checks++;
      if (id_inst !== e_inst || id_32 !== (n_ret == 2) || id_err !== e_err) begin
        errors++; $display("FAIL sb_inst got=%h/%0b/%0b exp=%h/%0b/%0b", id_inst, id_32, id_err, e_inst, n_ret == 2, e_err);
      end
    end
    if (wr) begin
      checks++;
      if (upd_inst[wr_pos*16 +: 16] !== data[15:0] || upd_err[wr_pos] !== err) begin
        errors++; $display("FAIL sb_upd0 got=%h exp=%h", upd_inst[wr_pos*16 +: 16], data[15:0]);
      end
      if (num == 2'd2) begin
        checks++;
        if (upd_inst[((wr_pos + 1) % N)*16 +: 16] !== data[31:16] || upd_err[(wr_pos + 1) % N] !== err) begin
          errors++; $display("FAIL sb_upd1 got=%h exp=%h", upd_inst[((wr_pos + 1) % N)*16 +: 16], data[31:16]);
        end
      end
    end
    if (fl) begin
      model_clear();
    end else begin
      if (e_vld && ac) begin
        for (int k = 0; k < n_ret; k++) void'(exp_q.pop_front());
        rd_pos = (rd_pos + n_ret) % N;
      end
      if (wr) begin
        exp_q.push_back({err, data[15:0]});
        if (num == 2'd2) exp_q.push_back({err, data[31:16]});
        wr_pos = (wr_pos + int'(num)) % N;
      end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * N && exp_q.size() > 0; k++) drive_cycle(0, 2'd1, 0, 0, 1, 0);
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b exp=1", buf_empty); end
  endtask

  task automatic test_reset();
    rst_b = 0; set_idle(); model_clear();
    #2;
    checks++; if (id_vld !== 0 || buf_empty !== 1 || fetch_rdy !== 1 || buf_full !== 0) begin
      errors++; $display("FAIL reset vld=%0b empty=%0b rdy=%0b full=%0b exp 0/1/1/0", id_vld, buf_empty, fetch_rdy, buf_full);
    end
    @(posedge clk); @(negedge clk); rst_b = 1; @(posedge clk); #1;
  endtask

  task automatic test_basic_16();
    drive_cycle(1, 2'd2, 32'h0001_4501, 0, 0, 0);
    checks++; if (id_vld !== 1 || id_inst !== 32'h0000_4501 || id_32 !== 0) begin
      errors++; $display("FAIL basic_first got=%0b %h exp=1 00004501", id_vld, id_inst);
    end
    drive_cycle(0, 2'd1, 0, 0, 1, 0);
    checks++; if (id_vld !== 1 || id_inst !== 32'h0000_0001) begin
      errors++; $display("FAIL basic_second got=%0b %h exp=1 00000001", id_vld, id_inst);
    end
    drain();
  endtask

  task automatic test_basic_32();
    drive_cycle(1, 2'd2, 32'h0000_0093, 0, 0, 0);
    checks++; if (id_vld !== 1 || id_inst !== 32'h0000_0093 || id_32 !== 1 || buf_empty !== 0) begin
      errors++; $display("FAIL addi32 got=%0b %h 32=%0b exp=1 00000093 1", id_vld, id_inst, id_32);
    end
    drive_cycle(0, 2'd1, 0, 0, 1, 0);
    checks++; if (buf_empty !== 1 || id_vld !== 0) begin
      errors++; $display("FAIL addi32_retire empty=%0b vld=%0b exp=1 0", buf_empty, id_vld);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < N && rd_pos != N - 1; k++) begin
      drive_cycle(1, 2'd1, 32'h0000_0001, 0, 0, 0);
      drive_cycle(0, 2'd1, 0, 0, 1, 0);
    end
    drive_cycle(1, 2'd2, 32'h1234_0297, 0, 0, 0);
    drive_cycle(1, 2'd2, 32'h2222_1111, 0, 0, 0);
    drive_cycle(1, 2'd2, 32'h4444_3330, 0, 0, 0);
    drive_cycle(1, 2'd1, 32'h0000_5555, 0, 0, 0);
    checks++; if (fetch_rdy !== 0 || buf_full !== 0) begin
      errors++; $display("FAIL wrap_rdy rdy=%0b full=%0b exp=0 0", fetch_rdy, buf_full);
    end
    checks++; if (id_vld !== 1 || id_inst !== 32'h1234_0297 || id_32 !== 1) begin
      errors++; $display("FAIL wrap_inst got=%0b %h exp=1 12340297", id_vld, id_inst);
    end
    drive_cycle(1, 2'd1, 32'h0000_7777, 0, 1, 0);
    checks++; if (fetch_rdy !== 1 || id_inst !== 32'h0000_1111) begin
      errors++; $display("FAIL wrap_after rdy=%0b inst=%h exp=1 00001111", fetch_rdy, id_inst);
    end
    drain();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) drive_cycle(1, 2'd2, 32'h0101_0202 + k, 0, 0, 0);
    checks++; if (buf_full !== 1 || fetch_rdy !== 0) begin
      errors++; $display("FAIL full full=%0b rdy=%0b exp=1 0", buf_full, fetch_rdy);
    end
    drive_cycle(1, 2'd2, 32'hFFFF_FFFF, 0, 1, 0);
    drain();
  endtask

  task automatic test_partial_32();
    drive_cycle(1, 2'd1, 32'h0000_0017, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (id_vld !== 0) begin errors++; $display("FAIL partial_hold got=%0b exp=0", id_vld); end
      drive_cycle(0, 2'd1, 0, 0, 1, 0);
    end
    drive_cycle(1, 2'd1, 32'h0000_ABCD, 0, 0, 0);
    checks++; if (id_vld !== 1 || id_inst !== 32'hABCD_0017 || id_32 !== 1) begin
      errors++; $display("FAIL partial_done got=%0b %h exp=1 abcd0017", id_vld, id_inst);
    end
    drain();
  endtask

  task automatic test_acc_err();
    drive_cycle(1, 2'd2, 32'h0000_0003, 1, 0, 0);
    checks++; if (id_vld !== 1 || id_err !== 1 || id_32 !== 0 || id_inst !== 32'h0000_0003) begin
      errors++; $display("FAIL acc_err got=%0b err=%0b 32=%0b %h exp=1 1 0 00000003", id_vld, id_err, id_32, id_inst);
    end
    drive_cycle(0, 2'd1, 0, 0, 1, 0);
    checks++; if (buf_empty !== 0 || id_vld !== 1 || id_err !== 1) begin
      errors++; $display("FAIL acc_err_one empty=%0b vld=%0b exp=0 1", buf_empty, id_vld);
    end
    drain();
  endtask

  task automatic test_flush();
    drive_cycle(1, 2'd2, 32'h3333_4444, 0, 0, 0);
    drive_cycle(1, 2'd2, 32'h5555_6666, 0, 1, 1);
    checks++; if (buf_empty !== 1 || id_vld !== 0 || fetch_rdy !== 1) begin
      errors++; $display("FAIL flush empty=%0b vld=%0b rdy=%0b exp=1 0 1", buf_empty, id_vld, fetch_rdy);
    end
    drive_cycle(0, 2'd1, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int k = 0; k < 400; k++) begin
      d = $urandom;
      drive_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(1, 2)), d,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0));
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) drive_cycle(1, 2'd2, 32'h1111_2222, 0, 0, 0);
    #3; rst_b = 0; #1;
    checks++; if (id_vld !== 0 || buf_empty !== 1 || fetch_rdy !== 1) begin
      errors++; $display("FAIL reset_mid vld=%0b empty=%0b rdy=%0b exp=0 1 1", id_vld, buf_empty, fetch_rdy);
    end
    model_clear();
    @(negedge clk); rst_b = 1; @(posedge clk); #1;
    drive_cycle(1, 2'd2, 32'h0001_4501, 0, 0, 0);
    drain();
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_basic_16();
    test_basic_32();
    test_wrap();
    test_full();
    test_partial_32();
    test_acc_err();
    test_flush();
    test_random();
    drain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
